// File: rtl/avalon_st_pkg.sv
// Shared beat layout, framing state encodings and counter helper for the
// Avalon-ST FIFO slice.
package avalon_st_pkg;

  // Sideband bits are packed directly above the data field of a stored beat.
  localparam int SOP_OFS   = 0;
  localparam int EOP_OFS   = 1;
  localparam int ERR_OFS   = 2;
  localparam int CTRL_W    = 3;
  localparam int SAT_MAX_W = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_e;

  function automatic int beat_w(input int data_w);
    return data_w + CTRL_W;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int unsigned w);
    logic [SAT_MAX_W-1:0] lim;
    lim = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
    return (v >= lim) ? v : v + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/avalon_st_fifo_mem.sv
// Beat storage for the FIFO slice: one synchronous write port and an
// asynchronous read port so the head is visible without a read cycle.
module avalon_st_fifo_mem #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/avalon_st_fifo_slice.sv
// First-word-fall-through Avalon-ST buffer stage with registered sink ready
// and per-stream packet, error and framing-violation counters.
//
// Framing FSM states:
//   state  | meaning
//   IDLE   | between packets, next pushed beat must carry sop
//   IN_PKT | inside a packet, waiting for the eop beat
module avalon_st_fifo_slice
  import avalon_st_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                     clock_clk,
  input  logic                     clock_rst,
  input  logic [DATA_W-1:0]        asi_data,
  input  logic                     asi_valid,
  output logic                     asi_ready,
  input  logic                     asi_startofpacket,
  input  logic                     asi_endofpacket,
  input  logic                     asi_error,
  output logic [DATA_W-1:0]        aso_data,
  output logic                     aso_valid,
  input  logic                     aso_ready,
  output logic                     aso_startofpacket,
  output logic                     aso_endofpacket,
  output logic                     aso_error,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         pkt_count,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         frame_err_count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int BEAT_W = beat_w(DATA_W);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_fill, w_fill_nxt;
  logic              r_asi_ready;
  logic              w_push, w_pop, w_viol;
  logic [BEAT_W-1:0] w_wr_beat, w_rd_beat;
  logic [CNT_W-1:0]  r_pkt_count, r_err_count, r_frame_err_count;
  frame_state_e      r_state, w_state_nxt;

  assign w_push = asi_valid & r_asi_ready;
  assign w_pop  = aso_valid & aso_ready;

  always_comb begin
    w_wr_beat                    = '0;
    w_wr_beat[DATA_W-1:0]        = asi_data;
    w_wr_beat[DATA_W + SOP_OFS]  = asi_startofpacket;
    w_wr_beat[DATA_W + EOP_OFS]  = asi_endofpacket;
    w_wr_beat[DATA_W + ERR_OFS]  = asi_error;
  end

  avalon_st_fifo_mem #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (clock_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_beat),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_beat)
  );

  always_comb begin
    w_fill_nxt = r_fill;
    case ({w_push, w_pop})
      2'b10:   w_fill_nxt = r_fill + (AW+1)'(1);
      2'b01:   w_fill_nxt = r_fill - (AW+1)'(1);
      default: w_fill_nxt = r_fill;
    endcase
  end

  // Ready is derived from next occupancy, so a pop while full reopens the
  // sink only on the following cycle.
  always_ff @(posedge clock_clk) begin
    if (clock_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_asi_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_fill      <= w_fill_nxt;
      r_asi_ready <= (w_fill_nxt != FULL_LVL);
    end
  end

  always_ff @(posedge clock_clk) begin
    if (clock_rst) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_viol      = 1'b0;
    if (w_push) begin
      case (r_state)
        IDLE: begin
          if (!asi_startofpacket)    w_viol      = 1'b1;
          else if (!asi_endofpacket) w_state_nxt = IN_PKT;
        end
        IN_PKT: begin
          if (asi_startofpacket) w_viol      = 1'b1;
          if (asi_endofpacket)   w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_clk) begin
    if (clock_rst) begin
      r_pkt_count       <= '0;
      r_err_count       <= '0;
      r_frame_err_count <= '0;
    end else begin
      if (w_push && asi_endofpacket)
        r_pkt_count <= CNT_W'(sat_inc(SAT_MAX_W'(r_pkt_count), CNT_W));
      if (w_push && asi_endofpacket && asi_error)
        r_err_count <= CNT_W'(sat_inc(SAT_MAX_W'(r_err_count), CNT_W));
      if (w_viol)
        r_frame_err_count <= CNT_W'(sat_inc(SAT_MAX_W'(r_frame_err_count), CNT_W));
    end
  end

  assign asi_ready         = r_asi_ready;
  assign aso_valid         = (r_fill != '0);
  assign aso_data          = w_rd_beat[DATA_W-1:0];
  assign aso_startofpacket = w_rd_beat[DATA_W + SOP_OFS];
  assign aso_endofpacket   = w_rd_beat[DATA_W + EOP_OFS];
  assign aso_error         = w_rd_beat[DATA_W + ERR_OFS];
  assign fill_level        = r_fill;
  assign pkt_count         = r_pkt_count;
  assign err_count         = r_err_count;
  assign frame_err_count   = r_frame_err_count;

endmodule

// File: doc/avalon_st_fifo_slice.md
Name: avalon_st_fifo_slice

Overview:
- Parametrised successor to the 64-bit Avalon-ST passthrough stage in the PCIe datapath. It buffers sink beats (data, sop, eop, error) in a first-word-fall-through FIFO of configurable width and depth.
- It breaks the ready/valid combinational path between the two sides.
- It keeps per-stream statistics: completed packets, errored packets and framing violations.
- It sits between the PCIe core's streaming interface and the user logic.

Parameters:
- DATA_W, 64, width of asi_data/aso_data (any value ≥ 8).
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- CNT_W, 32, width of the statistics counters.

Ports:
- clock_clk  in  1  single clock; all logic on the rising edge.
- clock_rst  in  1  reset, synchronous, active-high.
- asi_data  in  DATA_W  sink beat data.
- asi_valid  in  1  sink beat valid.
- asi_ready  out  1  sink may present a beat; registered, equals !full.
- asi_startofpacket  in  1  first beat of packet.
- asi_endofpacket  in  1  last beat of packet.
- asi_error  in  1  beat carries error; qualified at eop.
- aso_data  out  DATA_W  source beat data (head of FIFO).
- aso_valid  out  1  FIFO non-empty.
- aso_ready  in  1  downstream accepts.
- aso_startofpacket  out  1  head sop.
- aso_endofpacket  out  1  head eop.
- aso_error  out  1  head error.
- fill_level  out  $clog2(DEPTH)+1  entries currently stored.
- pkt_count  out  CNT_W  eop beats accepted on the sink.
- err_count  out  CNT_W  eop beats accepted with asi_error=1.
- frame_err_count  out  CNT_W  framing violations on the sink.

Behaviour:
- Definitions: push = asi_valid & asi_ready; pop = aso_valid & aso_ready.
- Reset (clock_rst=1 at an edge) clears all state:
  - aso_valid=0, asi_ready=0 during the reset cycle, then 1 on the first cycle after reset.
  - fill_level=0; all counters 0; framing state IDLE.
  - A packet in flight at reset is discarded; no flush beat is emitted.
- Latency: a beat pushed at edge N is visible on aso_* with aso_valid=1 after edge N. Minimum latency is 1 cycle and there is no combinational path from asi to aso.
- Throughput: one beat per cycle sustained whenever fill_level < DEPTH.
- asi_ready is registered and depends only on occupancy; it never depends combinationally on aso_ready.
  - asi_ready=0 only when fill_level==DEPTH.
  - When full, a simultaneous pop does not enable a push in the same cycle; asi_ready rises the cycle after the pop.
- Simultaneous push and pop when not full and not empty: fill_level is unchanged and both pointers advance.
- Push and pop when fill_level==1: the new beat becomes head on the next cycle and aso_valid stays 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fill_level is maintained as a separate counter.
- aso_* outputs hold stable while aso_valid=1 and aso_ready=0.
- aso_data, sop, eop and error values are don't-care while aso_valid=0; the bench must not check them.
- Framing FSM, evaluated on push only:
  - IDLE: sop=1 & eop=1 → IDLE (single-beat packet); sop=1 & eop=0 → IN_PKT; sop=0 → violation, stay IDLE.
  - IN_PKT: sop=1 → violation, restart packet (stay IN_PKT, or go IDLE if eop=1); eop=1 → IDLE; otherwise stay IN_PKT.
  - Violation beats are still stored and forwarded unmodified. The block counts violations only and never drops beats.
- Counters:
  - pkt_count += 1 on every pushed eop.
  - err_count += 1 on a pushed eop with error=1.
  - frame_err_count += 1 per violation.
  - All counters saturate at 2^CNT_W−1 and do not wrap.
  - Counters update the edge after the push.

Decomposition:
- Shared package avalon_st_pkg holds:
  - beat field offsets: SOP, EOP and ERR bit positions above DATA_W;
  - BEAT_W = DATA_W+3;
  - framing state encodings IDLE/IN_PKT;
  - the saturating-increment function.
- One sub-module, avalon_st_fifo_mem: a BEAT_W×DEPTH storage array with one write port and a combinational read port.
- Pointers, occupancy, framing FSM and counters stay in the top level.

Test Plan:
- Continuous beats, aso_ready=1, DEPTH=4 → aso sequence identical to input, 1-cycle latency, fill_level ≤ 1, asi_ready never drops.
- aso_ready=0, push 5 beats → first 4 accepted, asi_ready=0 after the 4th push, fill_level=4. Then assert aso_ready for 1 cycle → asi_ready=1 on the following cycle and the 5th beat is accepted.
- Packets: 3-beat, 1-beat, then 2-beat with error at eop → pkt_count=3, err_count=1, frame_err_count=0; aso_error=1 only on the last output beat.
- Framing violations: beat with sop=0 while IDLE, then sop=1 twice without eop → frame_err_count=2 and all 3 beats forwarded.
- Reset asserted mid-packet with fill_level=3 → next cycle aso_valid=0, fill_level=0, counters 0. A following beat with sop=0 is counted as a violation, so the FSM is confirmed back in IDLE.
- CNT_W=4, send 17 eop beats → pkt_count saturates at 15; random aso_ready backpressure run checked against a scoreboard with no loss or duplication across pointer wrap.
